// File: rtl/arb2_rr_pkt.sv
// Two-input packet-aware round-robin arbiter with a one-entry registered
// output stage. Produces the select for a 2:1 payload mux (0=A, 1=B) and
// captures the muxed beat into the output register on every accepted beat.
// Once a stream starts a multi-beat packet it keeps the grant until its
// last beat is accepted; the round-robin pointer moves only at packet end.

module arb2_rr_pkt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,

  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,

  output logic             sel,

  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLockA = 2'd1;
  localparam logic [1:0] StLockB = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             sel_q, sel_c;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_src_q, out_src_d;

  logic             space;
  logic             xfer_a, xfer_b;
  logic [WIDTH-1:0] mux_data;
  logic             mux_last;

  // The output slot can take a new beat when empty or draining this cycle.
  assign space = !out_valid_q || out_ready;

  // Select: fixed while locked, arbitrated in idle; with no requester the
  // previous select is kept so the mux does not toggle needlessly.
  always_comb begin
    sel_c = sel_q;
    case (state_q)
      StLockA: sel_c = 1'b0;
      StLockB: sel_c = 1'b1;
      default: begin
        if (a_valid && !b_valid) begin
          sel_c = 1'b0;
        end else if (!a_valid && b_valid) begin
          sel_c = 1'b1;
        end else if (a_valid && b_valid) begin
          sel_c = rr_ptr_q;
        end
      end
    endcase
  end

  assign sel = sel_c;

  // Readies are gated by rst_n so nothing is accepted while reset is held.
  assign a_ready = rst_n && space && !sel_c && (state_q != StLockB);
  assign b_ready = rst_n && space &&  sel_c && (state_q != StLockA);

  assign xfer_a = a_valid && a_ready;
  assign xfer_b = b_valid && b_ready;

  // Bitwise 2:1 payload mux steered by sel.
  assign mux_data = sel_c ? b_data : a_data;
  assign mux_last = sel_c ? b_last : a_last;

  // Packet lock and round-robin pointer next state.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      StIdle: begin
        if (xfer_a) begin
          if (a_last) begin
            rr_ptr_d = 1'b1;
          end else begin
            state_d = StLockA;
          end
        end else if (xfer_b) begin
          if (b_last) begin
            rr_ptr_d = 1'b0;
          end else begin
            state_d = StLockB;
          end
        end
      end
      StLockA: begin
        if (xfer_a && a_last) begin
          state_d  = StIdle;
          rr_ptr_d = 1'b1;
        end
      end
      StLockB: begin
        if (xfer_b && b_last) begin
          state_d  = StIdle;
          rr_ptr_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output register next state: load on any transfer, else drain, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    if (xfer_a || xfer_b) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_last_d  = mux_last;
      out_src_d   = sel_c;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= 1'b0;
      sel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_c;
    end
  end

  // Output stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;

  // At most one stream is ever accepted in a cycle.
  a_one_ready: assert property (@(posedge clk) disable iff (!rst_n) !(a_ready && b_ready));

  // A stalled output beat is held unchanged.
  a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_src)));

endmodule

// File: tb/tb_arb2_rr_pkt.sv
// Directed bench for arb2_rr_pkt: reset, contention, packet lock, lock with
// gaps, backpressure and mid-packet reset, each with hand-computed results.

module tb_arb2_rr_pkt;

  logic       clk;
  logic       rst_n;
  logic       a_valid, b_valid;
  logic [7:0] a_data, b_data;
  logic       a_last, b_last;
  logic       a_ready, b_ready;
  logic       sel;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       out_last, out_src;

  int passed;
  int total;

  arb2_rr_pkt #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_last    (a_last),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_last    (b_last),
    .b_ready   (b_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    a_data = 8'($urandom); b_data = 8'($urandom);
    a_last = 1'($urandom); b_last = 1'($urandom);
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", out_valid); else passed++;
    total++; if (out_data !== 8'h00) $display("FAIL rst_data got %h exp 00", out_data); else passed++;
    total++; if (out_src !== 1'b0) $display("FAIL rst_src got %b exp 0", out_src); else passed++;
    total++; if (out_last !== 1'b0) $display("FAIL rst_last got %b exp 0", out_last); else passed++;
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    total++; if (a_ready !== 1'b0) $display("FAIL rst_a_ready got %b exp 0", a_ready); else passed++;
    total++; if (b_ready !== 1'b0) $display("FAIL rst_b_ready got %b exp 0", b_ready); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (sel !== 1'b0) $display("FAIL idle_sel got %b exp 0", sel); else passed++;
    total++; if (a_ready !== 1'b1) $display("FAIL idle_a_ready got %b exp 1", a_ready); else passed++;
    total++; if (b_ready !== 1'b0) $display("FAIL idle_b_ready got %b exp 0", b_ready); else passed++;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL idle_valid%0d got %b exp 0", i, out_valid); else passed++;
    end
  endtask

  task automatic test_contention();
    logic [7:0] exp_d;
    a_valid = 1'b1; a_data = 8'h11; a_last = 1'b1;
    b_valid = 1'b1; b_data = 8'h22; b_last = 1'b1;
    out_ready = 1'b1;
    #1;
    total++; if (sel !== 1'b0) $display("FAIL cont_sel_first got %b exp 0", sel); else passed++;
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b0)
      $display("FAIL cont_ready_first got %b%b exp 10", a_ready, b_ready); else passed++;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_d = (i % 2 == 0) ? 8'h11 : 8'h22;
      if (i == 3) begin
        a_valid = 1'b0; b_valid = 1'b0;
      end
      total++; if (out_valid !== 1'b1) $display("FAIL cont_valid%0d got %b exp 1", i, out_valid); else passed++;
      total++; if (out_data !== exp_d) $display("FAIL cont_data%0d got %h exp %h", i, out_data, exp_d); else passed++;
      total++; if (out_src !== 1'(i % 2)) $display("FAIL cont_src%0d got %b exp %b", i, out_src, 1'(i % 2)); else passed++;
      if (i < 3) begin
        #1;
        total++; if (sel !== 1'((i + 1) % 2)) $display("FAIL cont_sel%0d got %b exp %b", i, sel, 1'((i + 1) % 2)); else passed++;
      end
    end
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL cont_drain got %b exp 0", out_valid); else passed++;
  endtask

  task automatic test_packet_lock();
    logic [7:0] beats [3];
    beats[0] = 8'hA0; beats[1] = 8'hA1; beats[2] = 8'hA2;
    b_valid = 1'b1; b_data = 8'hB0; b_last = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; a_data = beats[i]; a_last = (i == 2);
      #1;
      total++; if (b_ready !== 1'b0) $display("FAIL lock_b_ready%0d got %b exp 0", i, b_ready); else passed++;
      total++; if (a_ready !== 1'b1) $display("FAIL lock_a_ready%0d got %b exp 1", i, a_ready); else passed++;
      tick();
      total++; if (out_data !== beats[i] || out_src !== 1'b0 || out_valid !== 1'b1)
        $display("FAIL lock_beat%0d got %h/%b/%b exp %h/0/1", i, out_data, out_src, out_valid, beats[i]);
      else passed++;
    end
    total++; if (out_last !== 1'b1) $display("FAIL lock_last got %b exp 1", out_last); else passed++;
    a_valid = 1'b0;
    #1;
    total++; if (b_ready !== 1'b1) $display("FAIL lock_b_after got %b exp 1", b_ready); else passed++;
    tick();
    total++; if (out_data !== 8'hB0 || out_src !== 1'b1)
      $display("FAIL lock_b_beat got %h/%b exp b0/1", out_data, out_src); else passed++;
    b_valid = 1'b0;
    tick();
  endtask

  task automatic test_lock_gap();
    a_valid = 1'b1; a_data = 8'hA0; a_last = 1'b0;
    b_valid = 1'b1; b_data = 8'hB1; b_last = 1'b1;
    out_ready = 1'b1;
    tick();
    total++; if (out_data !== 8'hA0 || out_src !== 1'b0)
      $display("FAIL gap_first got %h/%b exp a0/0", out_data, out_src); else passed++;
    a_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (b_ready !== 1'b0 || sel !== 1'b0)
        $display("FAIL gap_block%0d got b_ready=%b sel=%b exp 0 0", i, b_ready, sel); else passed++;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL gap_empty%0d got %b exp 0", i, out_valid); else passed++;
    end
    a_valid = 1'b1; a_data = 8'hA1; a_last = 1'b1;
    #1;
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b0)
      $display("FAIL gap_resume got %b%b exp 10", a_ready, b_ready); else passed++;
    tick();
    total++; if (out_data !== 8'hA1 || out_last !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL gap_a1 got %h/%b/%b exp a1/1/1", out_data, out_last, out_valid); else passed++;
    a_valid = 1'b0;
    tick();
    total++; if (out_data !== 8'hB1 || out_src !== 1'b1)
      $display("FAIL gap_b got %h/%b exp b1/1", out_data, out_src); else passed++;
    b_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    a_valid = 1'b1; a_data = 8'h5A; a_last = 1'b1;
    b_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    total++; if (out_data !== 8'h5A || out_valid !== 1'b1)
      $display("FAIL bp_load got %h/%b exp 5a/1", out_data, out_valid); else passed++;
    out_ready = 1'b0;
    a_data = 8'h77;
    b_valid = 1'b1; b_data = 8'h33; b_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (a_ready !== 1'b0 || b_ready !== 1'b0)
        $display("FAIL bp_ready%0d got %b%b exp 00", i, a_ready, b_ready); else passed++;
      tick();
      total++; if (out_data !== 8'h5A || out_valid !== 1'b1)
        $display("FAIL bp_hold%0d got %h/%b exp 5a/1", i, out_data, out_valid); else passed++;
    end
    out_ready = 1'b1;
    #1;
    // A sent last, so B wins the tie.
    total++; if (b_ready !== 1'b1 || a_ready !== 1'b0)
      $display("FAIL bp_release got %b%b exp 01", a_ready, b_ready); else passed++;
    tick();
    total++; if (out_data !== 8'h33 || out_src !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL bp_next got %h/%b/%b exp 33/1/1", out_data, out_src, out_valid); else passed++;
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_packet();
    a_valid = 1'b0;
    b_valid = 1'b1; b_data = 8'hC0; b_last = 1'b0;
    out_ready = 1'b1;
    tick();
    total++; if (out_data !== 8'hC0 || out_src !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL mid_load got %h/%b/%b exp c0/1/1", out_data, out_src, out_valid); else passed++;
    out_ready = 1'b0; b_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL mid_async got %b exp 0", out_valid); else passed++;
    total++; if (out_data !== 8'h00 || out_src !== 1'b0)
      $display("FAIL mid_fields got %h/%b exp 00/0", out_data, out_src); else passed++;
    tick();
    #2;
    rst_n = 1'b1;
    a_valid = 1'b1; a_data = 8'hAA; a_last = 1'b1;
    b_valid = 1'b1; b_data = 8'hBB; b_last = 1'b1;
    out_ready = 1'b1;
    #1;
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b0)
      $display("FAIL mid_grant got %b%b exp 10", a_ready, b_ready); else passed++;
    tick();
    total++; if (out_data !== 8'hAA || out_src !== 1'b0)
      $display("FAIL mid_first got %h/%b exp aa/0", out_data, out_src); else passed++;
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_contention();
    test_packet_lock();
    test_lock_gap();
    test_backpressure();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
